win_banner_ctrl: RTL and testbench

- Sequences the "WIN" text overlay for the XO game's VGA output.
- On a game-won pulse, slides the text sprite down from the top of the screen to a rest position, blinks it a fixed number of times, then holds it steady until the next game starts.
- Drives the sprite origin (x, y) that feeds the text renderer and gates that renderer's draw output into the final pixel_on.
- All motion updates happen only on frame boundaries, so the banner never tears mid-frame.

---
 rtl/win_banner_ctrl.sv | 128 ++++++++++++
 tb/tb_win_banner_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/win_banner_ctrl.sv
// "WIN" overlay sequencer: slides the text sprite down to its rest row, blinks it,
// then holds it until the next game. All motion is stepped on frame boundaries.
`timescale 1ns/1ps
module win_banner_ctrl #(
  parameter int unsigned TARGET_X     = 171,
  parameter int unsigned TARGET_Y     = 188,
  parameter int unsigned SLIDE_STEP   = 8,
  parameter int unsigned BLINK_FRAMES = 15,
  parameter int unsigned BLINK_COUNT  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       win_event,
  input  logic       clear,
  input  logic       text_draw,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       pixel_on,
  output logic       busy,
  output logic       done
);

  // state   | meaning
  // S_IDLE  | banner hidden, waiting for a win
  // S_SLIDE | text moving down SLIDE_STEP px per frame
  // S_BLINK | text at rest, visibility toggling every BLINK_FRAMES frames
  // S_HOLD  | text steady and visible until clear

  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int TC_W = $clog2(BLINK_COUNT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SLIDE, S_BLINK, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [8:0]        y_q, y_d;
  logic              visible_q, visible_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [TC_W-1:0]   toggle_cnt_q, toggle_cnt_d;
  logic [9:0]        y_sum;
  logic [TC_W-1:0]   toggle_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      y_q          <= '0;
      visible_q    <= 1'b0;
      frame_cnt_q  <= '0;
      toggle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      y_q          <= y_d;
      visible_q    <= visible_d;
      frame_cnt_q  <= frame_cnt_d;
      toggle_cnt_q <= toggle_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    y_d          = y_q;
    visible_d    = visible_q;
    frame_cnt_d  = frame_cnt_q;
    toggle_cnt_d = toggle_cnt_q;
    // 10-bit sum so the overshoot past TARGET_Y cannot wrap before the compare
    y_sum        = {1'b0, y_q} + 10'(SLIDE_STEP);
    toggle_inc   = toggle_cnt_q + TC_W'(1);

    if (clear) begin
      state_d      = S_IDLE;
      y_d          = '0;
      visible_d    = 1'b0;
      frame_cnt_d  = '0;
      toggle_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          visible_d = 1'b0;
          if (win_event) begin
            state_d      = S_SLIDE;
            y_d          = '0;
            visible_d    = 1'b1;
            frame_cnt_d  = '0;
            toggle_cnt_d = '0;
          end
        end
        S_SLIDE: begin
          if (frame_tick) begin
            if (y_sum >= 10'(TARGET_Y)) begin
              state_d      = S_BLINK;
              y_d          = 9'(TARGET_Y);
              frame_cnt_d  = '0;
              toggle_cnt_d = '0;
            end else begin
              y_d = y_sum[8:0];
            end
          end
        end
        S_BLINK: begin
          if (frame_tick) begin
            if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
              frame_cnt_d  = '0;
              visible_d    = ~visible_q;
              toggle_cnt_d = toggle_inc;
              if (toggle_inc == TC_W'(BLINK_COUNT)) begin
                state_d   = S_HOLD;
                visible_d = 1'b1;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
          end
        end
        S_HOLD:  visible_d = 1'b1;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    x        = 10'(TARGET_X);
    y        = y_q;
    busy     = (state_q == S_SLIDE) || (state_q == S_BLINK);
    done     = (state_q == S_HOLD);
    pixel_on = visible_q & text_draw;
  end

endmodule

// File: tb/tb_win_banner_ctrl.sv
// Bench for win_banner_ctrl: directed walk through the banner life cycle, then random
// pulses, with every cycle compared against a tick-count model of the animation.
`timescale 1ns/1ps
module tb_win_banner_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       win_event = 1'b0;
  logic       clear = 1'b0;
  logic       text_draw = 1'b0;
  logic [9:0] x;
  logic [8:0] y;
  logic       pixel_on, busy, done;

  int checks = 0;
  int errors = 0;

  win_banner_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .win_event(win_event),
    .clear(clear), .text_draw(text_draw), .x(x), .y(y),
    .pixel_on(pixel_on), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the animation is a pure function of frame ticks counted since the win.
  localparam int SLIDE_TICKS = (188 + 7) / 8;        // 24 ticks to reach rest
  localparam int HOLD_TICKS  = SLIDE_TICKS + 15 * 6; // 114 ticks to reach hold

  bit m_valid  = 0;
  bit m_active = 0;
  int m_n      = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_active = 0; m_n = 0;
    end else if (clear) begin
      m_active = 0; m_n = 0;
    end else if (!m_active) begin
      if (win_event) begin m_active = 1; m_n = 0; end
    end else if (frame_tick && m_n < HOLD_TICKS) begin
      m_n++;
    end
  end

  function automatic int model_y();
    if (!m_active) return 0;
    return (8 * m_n < 188) ? 8 * m_n : 188;
  endfunction

  function automatic bit model_vis();
    if (!m_active) return 0;
    if (m_n < SLIDE_TICKS) return 1;
    return (((m_n - SLIDE_TICKS) / 15) % 2) == 0;
  endfunction

  function automatic bit model_hold();
    return m_active && m_n >= HOLD_TICKS;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("x", int'(x), 171);
      chk("y", int'(y), model_y());
      chk("busy", int'(busy), int'(m_active && !model_hold()));
      chk("done", int'(done), int'(model_hold()));
      chk("pixel_on", int'(pixel_on), int'(model_vis() & text_draw));
    end
  end

  task automatic cyc(input logic ft, input logic w, input logic c, input logic td, input logic r);
    frame_tick = ft; win_event = w; clear = c; text_draw = td; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic td);
    cyc(1, 0, 0, td, 0);
    cyc(0, 0, 0, td, 0);
  endtask

  initial begin
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    chk("rst_y", int'(y), 0);
    chk("rst_x", int'(x), 171);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    for (int i = 0; i < 10; i++) tick(1);
    chk("idle_pix", int'(pixel_on), 0);
    chk("idle_y", int'(y), 0);
    chk("idle_busy", int'(busy), 0);

    cyc(0, 1, 0, 1, 0);
    chk("win_busy", int'(busy), 1);
    chk("win_pix", int'(pixel_on), 1);
    tick(1);
    chk("slide_1", int'(y), 8);
    for (int i = 2; i <= 23; i++) tick(1);
    chk("slide_23", int'(y), 184);
    tick(0);
    chk("slide_24", int'(y), 188);
    chk("slide_24_busy", int'(busy), 1);
    chk("blink_td0", int'(pixel_on), 0);

    for (int t = 1; t <= 90; t++) begin
      tick(1);
      case (t)
        14: chk("blink_14", int'(pixel_on), 1);
        15: chk("blink_15", int'(pixel_on), 0);
        29: chk("blink_29", int'(pixel_on), 0);
        30: chk("blink_30", int'(pixel_on), 1);
        45: chk("blink_45", int'(pixel_on), 0);
        60: chk("blink_60", int'(pixel_on), 1);
        75: chk("blink_75", int'(pixel_on), 0);
        89: chk("blink_89", int'(busy), 1);
        90: begin
          chk("hold_pix", int'(pixel_on), 1);
          chk("hold_done", int'(done), 1);
          chk("hold_busy", int'(busy), 0);
        end
        default: ;
      endcase
    end
    for (int i = 0; i < 20; i++) tick(1);
    chk("hold_stay", int'(done), 1);
    cyc(0, 0, 1, 1, 0);
    chk("clr_done", int'(done), 0);

    cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 24 + 20; i++) tick(1);
    chk("mid_blink_pix", int'(pixel_on), 0);
    chk("mid_blink_busy", int'(busy), 1);
    cyc(0, 0, 1, 1, 0);
    chk("clr_y", int'(y), 0);
    chk("clr_busy", int'(busy), 0);
    chk("clr_pix", int'(pixel_on), 0);
    for (int i = 0; i < 5; i++) tick(1);
    chk("clr_stay_y", int'(y), 0);
    chk("clr_stay_busy", int'(busy), 0);

    cyc(0, 1, 1, 1, 0);
    chk("winclr_busy", int'(busy), 0);
    chk("winclr_pix", int'(pixel_on), 0);

    cyc(1, 1, 0, 1, 0);
    chk("winft_busy", int'(busy), 1);
    chk("winft_y", int'(y), 0);
    tick(1);
    chk("winft_next", int'(y), 8);
    tick(1);
    cyc(0, 1, 0, 1, 0);
    chk("retrig_y", int'(y), 16);
    tick(1);
    chk("retrig_next", int'(y), 24);
    for (int i = 0; i < 9; i++) tick(1);
    chk("pre_rst_y", int'(y), 96);
    cyc(0, 0, 0, 1, 1);
    chk("rst_mid_y", int'(y), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_pix", int'(pixel_on), 0);
    cyc(0, 0, 0, 1, 0);

    for (int i = 0; i < 8000; i++) begin
      cyc(logic'($urandom_range(1) == 0),
          logic'($urandom_range(19) == 0),
          logic'($urandom_range(299) == 0),
          logic'($urandom_range(1)),
          logic'($urandom_range(999) == 0));
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
